// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: size codes, FSM states,
// alignment check and lane mask.
package load_store_unit_pkg;

  localparam int WORD = 64;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_LOAD = 2'b01,
    LSU_RMW  = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offset[0];
      SZ_W:    bad = |offset[1:0];
      SZ_D:    bad = |offset;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [WORD-1:0] lane_mask(input logic [1:0] size);
    logic [WORD-1:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      SZ_D:    m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane_align.sv
// Byte-lane alignment shared by loads (extract + extend) and sub-dword
// stores (mask + merge into the old memory word).
module byte_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            sext,
  input  logic [2:0]      offset,
  input  logic [WORD-1:0] rdata,
  input  logic [WORD-1:0] wdata,
  output logic [WORD-1:0] load_data,
  output logic [WORD-1:0] merged
);

  logic [5:0]      shamt_s;
  logic [WORD-1:0] shifted_s;
  logic [WORD-1:0] mask_s;

  assign shamt_s   = {offset, 3'b000};
  assign shifted_s = rdata >> shamt_s;
  assign mask_s    = lane_mask(size) << shamt_s;

  // Extend the extracted lane and merge store data into the old word
  always_comb begin
    load_data = shifted_s;
    case (size)
      SZ_B:    load_data = {{(WORD-8){sext & shifted_s[7]}}, shifted_s[7:0]};
      SZ_H:    load_data = {{(WORD-16){sext & shifted_s[15]}}, shifted_s[15:0]};
      SZ_W:    load_data = {{(WORD-32){sext & shifted_s[31]}}, shifted_s[31:0]};
      SZ_D:    load_data = shifted_s;
      default: load_data = shifted_s;
    endcase
    merged = (rdata & ~mask_s) | ((wdata << shamt_s) & mask_s);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns byte-addressed requests into word-indexed
// data_memory accesses, with lane extraction for loads and RMW for narrow stores.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [WORD-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            stall,
  output logic            resp_valid,
  output logic [WORD-1:0] resp_rdata,
  output logic            fault,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_address,
  output logic [WORD-1:0] mem_write_data,
  input  logic [WORD-1:0] mem_read_data
);

  lsu_state_e      state_r;
  logic [1:0]      size_r;
  logic            signed_r;
  logic [2:0]      offset_r;
  logic [IDX_W-1:0] idx_r;
  logic [WORD-1:0] wdata_r;
  logic            resp_valid_r;
  logic            fault_r;
  logic [WORD-1:0] resp_rdata_r;

  logic            can_accept_s;
  logic            accept_s;
  logic            oor_s;
  logic            bad_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [WORD-1:0] load_data_s;
  logic [WORD-1:0] merged_s;
  logic            mem_read_s;
  logic            mem_write_s;
  logic [WORD-1:0] mem_address_s;
  logic [WORD-1:0] mem_write_data_s;
  logic            stall_s;

  // DONE already counts as idle so back-to-back requests lose no cycle
  assign can_accept_s = (state_r == LSU_IDLE) || (state_r == LSU_DONE);
  assign accept_s     = can_accept_s && req_valid && (req_read || req_write);
  assign req_idx_s    = req_addr[IDX_W+2:3];
  assign oor_s        = ({3'b000, req_addr[WORD-1:3]} >= WORD'(DEPTH));
  assign bad_s        = (req_read && req_write) || oor_s || misaligned(req_size, req_addr[2:0]);

  byte_lane_align u_align (
    .size      (size_r),
    .sext      (signed_r),
    .offset    (offset_r),
    .rdata     (mem_read_data),
    .wdata     (wdata_r),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // Memory strobes, address/data and stall for the current state and request
  always_comb begin
    mem_read_s       = 1'b0;
    mem_write_s      = 1'b0;
    mem_address_s    = {WORD{1'b0}};
    mem_write_data_s = {WORD{1'b0}};
    stall_s          = 1'b0;
    case (state_r)
      LSU_IDLE, LSU_DONE: begin
        if (accept_s && !bad_s) begin
          mem_address_s = {{(WORD-IDX_W){1'b0}}, req_idx_s};
          if (req_read) begin
            mem_read_s = 1'b1;
            stall_s    = 1'b1;
          end else if (req_size == SZ_D) begin
            mem_write_s      = 1'b1;
            mem_write_data_s = req_wdata;
          end else begin
            mem_read_s = 1'b1;
            stall_s    = 1'b1;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      LSU_LOAD: stall_s = 1'b1;
      LSU_RMW: begin
        stall_s          = 1'b1;
        mem_write_s      = 1'b1;
        mem_address_s    = {{(WORD-IDX_W){1'b0}}, idx_r};
        mem_write_data_s = merged_s;
      end
      default: stall_s = 1'b0;
    endcase
  end

  // Reset must block any in-flight write from reaching memory
  assign mem_read       = mem_read_s & ~reset;
  assign mem_write      = mem_write_s & ~reset;
  assign mem_address    = mem_address_s & {WORD{~reset}};
  assign mem_write_data = mem_write_data_s & {WORD{~reset}};
  assign stall          = stall_s;
  assign resp_valid     = resp_valid_r;
  assign fault          = fault_r;
  assign resp_rdata     = resp_rdata_r;

  // Sequencing FSM with latched request fields and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= LSU_IDLE;
      size_r       <= 2'b00;
      signed_r     <= 1'b0;
      offset_r     <= 3'b000;
      idx_r        <= {IDX_W{1'b0}};
      wdata_r      <= {WORD{1'b0}};
      resp_valid_r <= 1'b0;
      fault_r      <= 1'b0;
      resp_rdata_r <= {WORD{1'b0}};
    end else begin
      resp_valid_r <= 1'b0;
      fault_r      <= 1'b0;
      resp_rdata_r <= {WORD{1'b0}};
      case (state_r)
        LSU_IDLE, LSU_DONE: begin
          state_r <= LSU_IDLE;
          if (accept_s) begin
            size_r   <= req_size;
            signed_r <= req_signed;
            offset_r <= req_addr[2:0];
            idx_r    <= req_idx_s;
            wdata_r  <= req_wdata;
            if (bad_s) begin
              resp_valid_r <= 1'b1;
              fault_r      <= 1'b1;
            end else if (req_read) begin
              state_r <= LSU_LOAD;
            end else if (req_size == SZ_D) begin
              resp_valid_r <= 1'b1;
            end else begin
              state_r <= LSU_RMW;
            end
          end
        end
        LSU_LOAD: begin
          resp_valid_r <= 1'b1;
          resp_rdata_r <= load_data_s;
          state_r      <= LSU_IDLE;
        end
        LSU_RMW: begin
          resp_valid_r <= 1'b1;
          state_r      <= LSU_DONE;
        end
        default: state_r <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit with a transaction-level reference model
// and an attached synchronous-read data memory.
module tb_load_store_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_read, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        stall, resp_valid, fault, mem_read, mem_write;
  logic [63:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

  logic [63:0] bench_mem [DEPTH];
  logic [63:0] model_mem [DEPTH];
  logic        preload = 1'b0;

  logic        check_en = 1'b0;
  logic        exp_stall_chk, exp_stall, exp_mrd, exp_mwr, exp_rv, exp_fault;
  logic [63:0] exp_maddr, exp_mwd, exp_rdata;
  logic        pend_v, pend_f;
  logic [63:0] pend_d;
  logic [63:0] last_rdata, last_mwd;
  int          nvec = 0;
  int          nmis = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  function automatic logic [63:0] init_word(input int i);
    logic [31:0] u;
    u = i;
    return {u * 32'h9E37_79B9, ~u * 32'h85EB_CA6B};
  endfunction

  // data_memory: synchronous read, write on the clock edge
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) bench_mem[i] <= init_word(i);
    end else begin
      if (mem_write) bench_mem[mem_address[9:0]] <= mem_write_data;
      if (mem_read) mem_read_data <= bench_mem[mem_address[9:0]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model's expectation
  always @(negedge clk) begin
    if (check_en) begin
      nvec++;
      if (exp_stall_chk) chk("stall", {63'd0, stall}, {63'd0, exp_stall});
      chk("mem_read", {63'd0, mem_read}, {63'd0, exp_mrd});
      chk("mem_write", {63'd0, mem_write}, {63'd0, exp_mwr});
      chk("mem_address", mem_address, exp_maddr);
      chk("mem_write_data", mem_write_data, exp_mwd);
      chk("resp_valid", {63'd0, resp_valid}, {63'd0, exp_rv});
      chk("fault", {63'd0, fault}, {63'd0, exp_fault});
      if (exp_rv) chk("resp_rdata", resp_rdata, exp_rdata);
      if (resp_valid) last_rdata = resp_rdata;
      if (mem_write) last_mwd = mem_write_data;
    end
  end

  function automatic logic [63:0] model_load(input int idx, input int off, input int nb, input logic sg);
    logic [63:0] w, v;
    w = model_mem[idx];
    v = 64'd0;
    for (int b = 0; b < nb; b++) v[8*b +: 8] = w[8*(off+b) +: 8];
    if (sg && nb < 8 && v[8*nb-1]) for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] model_store(input int idx, input int off, input int nb, input logic [63:0] wd);
    logic [63:0] w;
    w = model_mem[idx];
    for (int b = 0; b < nb; b++) w[8*(off+b) +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_cycle();
    exp_stall_chk = 1'b1;
    exp_stall = 1'b0; exp_mrd = 1'b0; exp_mwr = 1'b0;
    exp_maddr = 64'd0; exp_mwd = 64'd0;
    exp_rv = pend_v; exp_fault = pend_f; exp_rdata = pend_d;
    pend_v = 1'b0; pend_f = 1'b0; pend_d = 64'd0;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_read = 1'($urandom); req_write = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    begin_cycle();
    tick();
  endtask

  task automatic do_txn(input logic r, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [63:0] a, input logic [63:0] wd);
    int nb, off, idx;
    logic flt;
    req_valid = 1'b1; req_read = r; req_write = w; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    nb  = 1 << sz;
    off = int'(a[2:0]);
    idx = int'(a[12:3]);
    flt = (r && w) || ((a & 64'(nb - 1)) != 64'd0) || (a >= 64'(DEPTH * 8));
    begin_cycle();
    if (flt) begin
      tick();
      pend_v = 1'b1; pend_f = 1'b1;
    end else if (w && nb == 8) begin
      exp_mwr = 1'b1; exp_maddr = 64'(idx); exp_mwd = wd;
      tick();
      model_mem[idx] = wd;
      pend_v = 1'b1;
    end else if (r) begin
      exp_stall = 1'b1; exp_mrd = 1'b1; exp_maddr = 64'(idx);
      tick();
      begin_cycle();
      exp_stall = 1'b1;
      tick();
      pend_v = 1'b1; pend_d = model_load(idx, off, nb, sg);
    end else begin
      exp_stall = 1'b1; exp_mrd = 1'b1; exp_maddr = 64'(idx);
      tick();
      begin_cycle();
      exp_stall = 1'b1; exp_mwr = 1'b1; exp_maddr = 64'(idx);
      exp_mwd = model_store(idx, off, nb, wd);
      tick();
      model_mem[idx] = model_store(idx, off, nb, wd);
      pend_v = 1'b1;
    end
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    int          kind;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
    pend_v = 1'b0; pend_f = 1'b0; pend_d = 64'd0;
    last_rdata = 64'd0; last_mwd = 64'd0;
    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_size = 2'b11;
    req_signed = 1'b0; req_addr = 64'h10; req_wdata = 64'd0;
    tick();
    preload = 1'b0;
    // reset: request ignored, no memory strobes, response regs cleared
    begin_cycle(); exp_stall_chk = 1'b0; check_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle();

    // dword store then dword load
    do_txn(1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122_3344_5566_7788);
    do_txn(1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0);
    idle();
    chk("lit_dword_load", last_rdata, 64'h1122_3344_5566_7788);

    // sign/zero extension
    do_txn(1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h0000_0000_0000_80FF);
    do_txn(1'b1, 1'b0, 2'b00, 1'b1, 64'h11, 64'd0);
    idle();
    chk("lit_ldursb", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_txn(1'b1, 1'b0, 2'b00, 1'b0, 64'h11, 64'd0);
    idle();
    chk("lit_ldurb", last_rdata, 64'h0000_0000_0000_0080);
    do_txn(1'b1, 1'b0, 2'b01, 1'b1, 64'h10, 64'd0);
    idle();
    chk("lit_ldursh", last_rdata, 64'hFFFF_FFFF_FFFF_80FF);

    // byte store read-modify-write
    do_txn(1'b0, 1'b1, 2'b11, 1'b0, 64'h08, 64'h1122_3344_5566_7788);
    do_txn(1'b0, 1'b1, 2'b00, 1'b0, 64'h0B, 64'h0000_0000_0000_00AB);
    idle();
    chk("lit_sturb_merge", last_mwd, 64'h1122_3344_AB66_7788);

    // faults: misaligned, out of range, read+write
    do_txn(1'b1, 1'b0, 2'b01, 1'b0, 64'h21, 64'd0);
    do_txn(1'b1, 1'b0, 2'b11, 1'b0, 64'h2000, 64'd0);
    do_txn(1'b1, 1'b1, 2'b11, 1'b0, 64'h10, 64'd0);
    idle();

    // reset during the merge cycle of a half store
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_size = 2'b01;
    req_signed = 1'b0; req_addr = 64'h08; req_wdata = 64'h0000_0000_0000_BEEF;
    begin_cycle(); exp_stall = 1'b1; exp_mrd = 1'b1; exp_maddr = 64'd1;
    tick();
    reset = 1'b1;
    begin_cycle(); exp_stall_chk = 1'b0;
    tick();
    reset = 1'b0;
    idle();
    do_txn(1'b1, 1'b0, 2'b11, 1'b0, 64'h08, 64'd0);
    idle();
    chk("lit_after_reset", last_rdata, 64'h1122_3344_AB66_7788);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 19);
      sz = 2'($urandom_range(0, 3));
      a = {51'd0, 7'($urandom_range(0, 127)), 6'd0} | 64'($urandom_range(0, 63));
      a[2:0] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : (3'($urandom) & ~3'((1 << sz) - 1));
      if ($urandom_range(0, 3) == 0) a[12:3] = 10'($urandom);
      if (kind == 19) a[63:13] = 51'($urandom_range(1, 1000)) << $urandom_range(0, 40);
      if (kind < 9 || kind == 19) do_txn(1'b1, 1'b0, sz, 1'($urandom), a, {$urandom, $urandom});
      else if (kind < 18) do_txn(1'b0, 1'b1, sz, 1'($urandom), a, {$urandom, $urandom});
      else do_txn(1'b1, 1'b1, sz, 1'($urandom), a, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    idle();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits in the memory stage between the EX/MEM pipeline register and data_memory.
- Converts byte-addressed ARMv8 load/store requests into the word-indexed, synchronous-read accesses data_memory expects.
- Performs byte-lane extraction with sign/zero extension for loads, and read-modify-write for sub-doubleword stores.
- Stalls the pipeline while a multi-cycle access is in flight.

Parameters:
- DEPTH, 1024, number of `WORD-wide entries in the attached data_memory (its SIZE).
- IDX_W, $clog2(DEPTH), width of the word index driven to data_memory.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present from EX/MEM.
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_size  in  2  00 byte, 01 half, 10 word32, 11 dword.
- req_signed  in  1  sign-extend the load result (LDURSB/LDURSH/LDURSW); ignored for dword and for stores.
- req_addr  in  `WORD  byte address.
- req_wdata  in  `WORD  store data, right-justified.
- stall  out  1  hold upstream; the request must be held stable while high.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  `WORD  load result, extended; 0 for stores and faults.
- fault  out  1  qualifies resp_valid: misaligned, out-of-range, or read and write both set.
- mem_read  out  1  to data_memory.
- mem_write  out  1  to data_memory.
- mem_address  out  `WORD  word index (req_addr >> 3), zero-extended.
- mem_write_data  out  `WORD  to data_memory.
- mem_read_data  in  `WORD  from data_memory; valid the cycle after mem_read.

Behaviour:
- Addressing and alignment
  - Little-endian; byte offset is addr[2:0].
  - Alignment is required: half needs addr[0]=0, word32 needs addr[1:0]=0, dword needs addr[2:0]=0.
  - The word index is addr[IDX_W+2:3]; any set bit in addr[`WORD-1:IDX_W+3] means out-of-range.
- Reset
  - state=IDLE; resp_valid, fault and resp_rdata are 0; latched request fields are 0.
  - While reset is high, mem_read and mem_write are forced to 0 combinationally.
- FSM states: IDLE, LOAD_DATA, RMW_MERGE, DONE.
- IDLE with req_valid, fault condition:
  - No memory access.
  - Next cycle: resp_valid=1, fault=1, resp_rdata=0. Stays IDLE. stall=0.
- IDLE with a dword store:
  - mem_write=1 and mem_address=index in the same cycle; mem_write_data=req_wdata.
  - stall=0; resp_valid pulses the next cycle.
- IDLE with a load:
  - mem_read=1 this cycle; latch size, signed and offset; go to LOAD_DATA.
  - stall=1 in the accept cycle, combinational from req.
- LOAD_DATA:
  - Extract the lane from mem_read_data at offset*8, then extend per size/signed.
  - Register the result into resp_rdata and set resp_valid=1 next cycle; go to IDLE.
  - stall=1.
  - Load latency is 2 cycles from accept to resp_valid.
- IDLE with a sub-dword store:
  - mem_read=1; latch the request; go to RMW_MERGE; stall=1.
- RMW_MERGE:
  - merged = (mem_read_data & ~mask) | ((wdata << offset*8) & mask).
  - mask is 0xFF / 0xFFFF / 0xFFFFFFFF shifted left by offset*8.
  - mem_write=1 with mem_address=latched index; go to DONE; stall=1.
- DONE:
  - resp_valid=1 for one cycle; go to IDLE; stall=0.
  - A new request may be accepted in this same cycle.
- Pulses and idle drive
  - resp_valid and fault are single-cycle pulses.
  - mem_read and mem_write are never both high.
  - When idle, mem_address and mem_write_data are driven 0.
- Reset in any non-IDLE state: return to IDLE; the pending response and memory write are discarded; memory is unchanged.

Decomposition:
- Additions to definitions.vh:
  - size codes `SZ_B/`SZ_H/`SZ_W/`SZ_D.
  - FSM state encodings `LSU_IDLE/`LSU_LOAD/`LSU_RMW/`LSU_DONE.
- Sub-module byte_lane_align, purely combinational: extract+extend for loads and mask+merge for stores, shared by both paths.

Test Plan:
1. Store dword 0x1122334455667788 at 0x10, then load dword 0x10 -> store: stall=0, mem_write one cycle. Load: resp_rdata=0x1122334455667788 two cycles after accept, stall high for 2 cycles.
2. Memory index 2 = 0x00000000000080FF; LDURSB 0x11 -> 0xFFFFFFFFFFFFFF80. Unsigned LDURB 0x11 -> 0x0000000000000080. LDURSH 0x10 -> 0xFFFFFFFFFFFF80FF.
3. Index 1 = 0x1122334455667788; STURB 0x0B data 0xAB -> mem_read in cycle 0, mem_write only in cycle 1 with 0x11223344AB667788; resp_valid in cycle 2.
4. LDURH at 0x21 -> fault=1 and resp_valid=1 next cycle, resp_rdata=0; mem_read and mem_write never asserted.
5. Dword load at 0x2000 (index 1024, DEPTH=1024), and a request with req_read=req_write=1 -> both produce fault=1; no memory access.
6. Reset asserted during the RMW_MERGE cycle of STURH 0x08 -> mem_write=0, stall=0 next cycle, no resp_valid; reading index 1 afterwards returns the original value.
